// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types for the data-memory arbiter and its starvation counter
package dmem_arbiter_pkg;

    localparam int WAIT_W     = 8;
    localparam int REQ_DATA_W = 32;
    localparam int REQ_ADDR_W = 9;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} dmem_arb_state_e;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [2:0]            func3;
    } dmem_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts consecutive blocked requester cycles and flags when the next one must be forced
module arb_starve_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    output logic hit
);

    localparam logic [WAIT_W-1:0] LIM_M1 = WAIT_W'(LIMIT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    assign hit = (cnt_q == LIM_M1);

    // any cycle that is not a blocked conflict restarts the count
    always_comb begin
        cnt_d = inc ? cnt_q + 1'b1 : '0;
    end

    // wait counter register, asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data memory between the core MEM stage (priority) and a DMA port with starvation relief
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DM_ADDRESS   = 9,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  dma_valid,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    input  logic [2:0]            dma_func3,
    output logic                  dma_ready,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [CNT_W-1:0]      conflict_cnt
);

    dmem_arb_state_e   state_q, state_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              core_req, conflict, forced, core_own, dma_go, starve_hit;

    assign core_req = core_rd | core_wr;
    assign conflict = core_req & dma_valid;
    assign forced   = (state_q == S_FORCE);
    assign core_own = !forced & core_req;
    assign dma_go   = dma_valid & (forced | !core_req);

    assign dma_rvalid   = rvalid_q;
    assign dma_rdata    = rdata_q;
    assign conflict_cnt = conflict_q;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (conflict & !forced),
        .hit   (starve_hit)
    );

    // grant mux; strobes are gated by reset so nothing reaches memory while reset is held
    always_comb begin
        mem_rd     = reset & (core_own ? (core_rd & !core_wr) : (dma_go & !dma_we));
        mem_wr     = reset & (core_own ? core_wr : (dma_go & dma_we));
        mem_addr   = core_own ? core_addr  : dma_go ? dma_addr  : '0;
        mem_wdata  = core_own ? core_wdata : dma_go ? dma_wdata : '0;
        mem_func3  = core_own ? core_func3 : dma_go ? dma_func3 : '0;
        dma_ready  = reset & dma_go;
        core_stall = forced;
        core_rdata = core_own ? mem_rdata : '0;
    end

    // next state, saturating conflict statistic and registered DMA read return
    always_comb begin
        state_d = S_IDLE;
        if (!forced && conflict) state_d = starve_hit ? S_FORCE : S_WAIT;
        conflict_d = (conflict && conflict_q != '1) ? conflict_q + 1'b1 : conflict_q;
        rvalid_d   = dma_ready & !dma_we;
        rdata_d    = rvalid_d ? mem_rdata : '0;
    end

    // state and output registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            conflict_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            conflict_q <= conflict_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0, reset = 1'b0;
    logic        core_rd, core_wr, dma_valid, dma_we;
    logic [8:0]  core_addr, dma_addr;
    logic [31:0] core_wdata, dma_wdata;
    logic [2:0]  core_func3, dma_func3;
    logic [31:0] core_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        core_stall, dma_ready, dma_rvalid, mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [2:0]  mem_func3;
    logic [15:0] conflict_cnt;

    logic [31:0] d2_core_rdata, d2_dma_rdata, d2_mem_wdata;
    logic        d2_core_stall, d2_dma_ready, d2_dma_rvalid, d2_mem_rd, d2_mem_wr;
    logic [8:0]  d2_mem_addr;
    logic [2:0]  d2_mem_func3;
    logic [3:0]  d2_conflict_cnt;

    logic [31:0] mem [512];

    typedef struct {logic [8:0] a; logic [31:0] d;} wr_t;
    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    wr_t         w;
    logic [31:0] r;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_func3(core_func3), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_func3(dma_func3), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    dmem_arbiter #(.STARVE_LIMIT(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_func3(core_func3), .core_rdata(d2_core_rdata), .core_stall(d2_core_stall),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_func3(dma_func3), .dma_ready(d2_dma_ready), .dma_rvalid(d2_dma_rvalid), .dma_rdata(d2_dma_rdata),
        .mem_rd(d2_mem_rd), .mem_wr(d2_mem_wr), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
        .mem_func3(d2_mem_func3), .mem_rdata(mem_rdata), .conflict_cnt(d2_conflict_cnt)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    // monitor: every memory write and every DMA read return must match the next queued expectation
    always @(negedge clk) begin
        if (mem_wr) begin
            if (wr_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", {23'b0, mem_addr}, {23'b0, w.a});
                chk("wr_data", mem_wdata, w.d);
            end
        end
        if (dma_rvalid) begin
            if (rd_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rvalid: got data %h expected no rvalid", dma_rdata);
            end else begin
                r = rd_q.pop_front();
                chk("dma_rdata", dma_rdata, r);
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                         input logic dv, input logic dw, input logic [8:0] da, input logic [31:0] dd);
        core_rd = cr; core_wr = cw; core_addr = ca; core_wdata = cd; core_func3 = 3'b010;
        dma_valid = dv; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_func3 = 3'b010;
    endtask

    task automatic idle();
        drive(0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // reset: a core write presented during reset must not reach memory
        drive(0, 1, 9'h010, 32'hDEADBEEF, 0, 0, 9'h0, 32'h0);
        smp();
        chk("rst_mem_wr", {31'b0, mem_wr}, 0);
        chk("rst_conflict", {16'b0, conflict_cnt}, 0);
        chk("rst_rvalid", {31'b0, dma_rvalid}, 0);
        chk("rst_stall", {31'b0, core_stall}, 0);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        nxt();
        reset = 1'b1;
        // core-only write
        drive(0, 1, 9'h010, 32'hDEADBEEF, 0, 0, 9'h0, 32'h0);
        wr_q.push_back('{9'h010, 32'hDEADBEEF});
        smp();
        chk("core_mem_wr", {31'b0, mem_wr}, 1);
        chk("core_stall", {31'b0, core_stall}, 0);
        chk("core_dma_ready", {31'b0, dma_ready}, 0);
        nxt();
        // DMA-only write then read
        drive(0, 0, 9'h0, 32'h0, 1, 1, 9'h020, 32'h12345678);
        wr_q.push_back('{9'h020, 32'h12345678});
        smp();
        chk("dmaw_ready", {31'b0, dma_ready}, 1);
        nxt();
        drive(0, 0, 9'h0, 32'h0, 1, 0, 9'h020, 32'h0);
        rd_q.push_back(32'h12345678);
        smp();
        chk("dmar_ready", {31'b0, dma_ready}, 1);
        chk("dmar_mem_rd", {31'b0, mem_rd}, 1);
        nxt();
        idle();
        smp();
        chk("dmar_rvalid", {31'b0, dma_rvalid}, 1);
        chk("mem_10", mem[9'h010], 32'hDEADBEEF);
        nxt();
        smp();
        chk("dmar_rvalid_pulse", {31'b0, dma_rvalid}, 0);
        nxt();
        // starvation: forced slot on the fifth conflict cycle
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 9'h010, 32'h0, 1, 1, 9'h030, 32'hA5A5A5A5);
            if (i == 4) wr_q.push_back('{9'h030, 32'hA5A5A5A5});
            smp();
            chk($sformatf("starve_stall_%0d", i), {31'b0, core_stall}, {31'b0, i == 4});
            chk($sformatf("starve_ready_%0d", i), {31'b0, dma_ready}, {31'b0, i == 4});
            chk($sformatf("starve_rdata_%0d", i), core_rdata, (i == 4) ? 32'h0 : 32'hDEADBEEF);
            chk($sformatf("lim1_stall_%0d", i), {31'b0, d2_core_stall}, {31'b0, i % 2 == 1});
            nxt();
        end
        idle();
        smp();
        chk("starve_conflict", {16'b0, conflict_cnt}, 5);
        chk("lim1_conflict", {28'b0, d2_conflict_cnt}, 5);
        nxt();
        // early release: core idles after two conflict cycles
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, 0, 9'h010, 32'h0, 1, 0, 9'h030, 32'h0);
            if (i == 2) rd_q.push_back(32'hA5A5A5A5);
            smp();
            chk($sformatf("early_ready_%0d", i), {31'b0, dma_ready}, {31'b0, i == 2});
            chk($sformatf("early_stall_%0d", i), {31'b0, core_stall}, 0);
            nxt();
        end
        idle();
        smp();
        chk("early_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("early_wait_cnt", {24'b0, dut.u_starve.cnt_q}, 0);
        chk("early_conflict", {16'b0, conflict_cnt}, 7);
        chk("lim1_conflict_2", {28'b0, d2_conflict_cnt}, 7);
        nxt();
        // reset asserted during the forced slot aborts the DMA write
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 9'h010, 32'h0, 1, 1, 9'h040, 32'h11111111);
            if (i == 4) reset = 1'b0;
            smp();
            chk($sformatf("rstf_ready_%0d", i), {31'b0, dma_ready}, 0);
            if (i == 4) begin
                chk("rstf_mem_wr", {31'b0, mem_wr}, 0);
                chk("rstf_stall", {31'b0, core_stall}, 0);
            end
            nxt();
        end
        reset = 1'b1;
        idle();
        smp();
        chk("rstf_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("rstf_conflict", {16'b0, conflict_cnt}, 0);
        chk("rstf_mem_40", {31'b0, mem[9'h040] === 32'h11111111}, 0);
        nxt();
        // saturation: 20 conflict cycles, narrow counter holds at all-ones
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 9'h010, 32'h0, 1, 0, 9'h030, 32'h0);
            if (i % 5 == 4) rd_q.push_back(32'hA5A5A5A5);
            smp();
            chk($sformatf("sat_ready_%0d", i), {31'b0, dma_ready}, {31'b0, i % 5 == 4});
            nxt();
        end
        idle();
        smp();
        chk("sat_conflict_16", {16'b0, conflict_cnt}, 20);
        chk("sat_conflict_4", {28'b0, d2_conflict_cnt}, 32'hF);
        nxt();
        smp();
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
